// File: rtl/step_sched_pkg.sv
// Shared types and defaults for the step scheduler: FSM state encoding,
// divider sizing defaults and the terminal-count helper.
package step_sched_pkg;

  localparam int unsigned BASE_SHIFT_DEF = 2;
  localparam int unsigned PRESCALE_W_DEF = 9;
  localparam int unsigned NUM_PHASES_DEF = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Last divider count of a period: 2^(base_shift+speed) - 1.
  function automatic logic [31:0] period_last(input logic [2:0]  speed,
                                              input int unsigned base_shift = BASE_SHIFT_DEF);
    return (32'd1 << (base_shift + 32'(speed))) - 32'd1;
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Programmable period divider: counts 2^(BASE_SHIFT+speed) cycles and emits a
// one-cycle tick; the speed setting is only re-sampled at period boundaries.
module rate_divider
  import step_sched_pkg::*;
#(
  parameter int unsigned BASE_SHIFT = BASE_SHIFT_DEF,
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic       run_i,
  input  logic       hold_i,
  input  logic [2:0] speed_i,
  output logic       tick_o
);

  if (PRESCALE_W < BASE_SHIFT + 7) begin : g_width_check
    $error("rate_divider: PRESCALE_W must be >= BASE_SHIFT+7");
  end

  localparam logic [PRESCALE_W-1:0] DIV_ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] div_q, div_d;
  logic [PRESCALE_W-1:0] div_last;
  logic [2:0]            speed_q, speed_d;

  assign div_last = PRESCALE_W'(period_last(speed_q, BASE_SHIFT));

  always_comb begin
    div_d   = div_q;
    speed_d = speed_q;
    tick_o  = 1'b0;
    if (load_i) begin
      div_d   = '0;
      speed_d = speed_i;
    end else if (run_i && !hold_i) begin
      if (div_q == div_last) begin
        div_d   = '0;
        tick_o  = 1'b1;
        speed_d = speed_i;
      end else begin
        div_d = div_q + DIV_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q   <= '0;
      speed_q <= '0;
    end else begin
      div_q   <= div_d;
      speed_q <= speed_d;
    end
  end

endmodule

// File: rtl/step_scheduler.sv
// Step rate controller: turns divider ticks into a single-entry valid/ready
// step request and walks a bouncing phase index on every accepted step.
module step_scheduler
  import step_sched_pkg::*;
#(
  parameter int unsigned BASE_SHIFT = BASE_SHIFT_DEF,
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF,
  parameter int unsigned NUM_PHASES = NUM_PHASES_DEF,
  parameter int unsigned PHASE_W    = $clog2(NUM_PHASES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         speed,
  input  logic               hold,
  input  logic               step_ready,
  output logic               step_valid,
  output logic [PHASE_W-1:0] phase,
  output logic               dir,
  output logic               overrun,
  output logic               running
);

  if (NUM_PHASES < 2) begin : g_phase_check
    $error("step_scheduler: NUM_PHASES must be >= 2");
  end

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(NUM_PHASES - 1);
  localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);

  state_e               state_q, state_d;
  logic                 valid_q, valid_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 dir_q, dir_d;
  logic                 overrun_q, overrun_d;
  logic                 tick;
  logic                 xfer;

  rate_divider #(
    .BASE_SHIFT (BASE_SHIFT),
    .PRESCALE_W (PRESCALE_W)
  ) u_rate_divider (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (state_q == ST_IDLE),
    .run_i   (state_q == ST_RUN),
    .hold_i  (hold),
    .speed_i (speed),
    .tick_o  (tick)
  );

  assign xfer = valid_q && step_ready;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    phase_d   = phase_q;
    dir_d     = dir_q;
    overrun_d = overrun_q;

    if (state_q == ST_IDLE) begin
      state_d = ST_RUN;
    end

    if (xfer) begin
      valid_d = 1'b0;
      if (dir_q) begin
        if (phase_q == PHASE_LAST) begin
          phase_d = phase_q - PHASE_ONE;
          dir_d   = 1'b0;
        end else begin
          phase_d = phase_q + PHASE_ONE;
        end
      end else begin
        if (phase_q == '0) begin
          phase_d = PHASE_ONE;
          dir_d   = 1'b1;
        end else begin
          phase_d = phase_q - PHASE_ONE;
        end
      end
    end

    // A tick that meets a pending, unaccepted step is dropped and flagged.
    if (tick) begin
      if (!valid_q || xfer) begin
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      phase_q   <= '0;
      dir_q     <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      phase_q   <= phase_d;
      dir_q     <= dir_d;
      overrun_q <= overrun_d;
    end
  end

  assign step_valid = valid_q;
  assign phase      = phase_q;
  assign dir        = dir_q;
  assign overrun    = overrun_q;
  assign running    = (state_q == ST_RUN);

endmodule

// File: tb/tb_step_scheduler.sv
// Scoreboard bench for step_scheduler: directed scenarios push expected
// transfers and state probes, a negedge monitor pops and compares them.
module tb_step_scheduler;

  logic       clk;
  logic       reset;
  logic [2:0] speed;
  logic       hold;
  logic       step_ready;
  logic       step_valid;
  logic [2:0] phase;
  logic       dir;
  logic       overrun;
  logic       running;

  step_scheduler #(
    .BASE_SHIFT (2),
    .PRESCALE_W (9),
    .NUM_PHASES (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .speed      (speed),
    .hold       (hold),
    .step_ready (step_ready),
    .step_valid (step_valid),
    .phase      (phase),
    .dir        (dir),
    .overrun    (overrun),
    .running    (running)
  );

  typedef struct packed {
    int         cyc;
    logic       valid;
    logic [2:0] ph;
    logic       dr;
    logic       ovr;
    logic       run;
  } probe_t;

  typedef struct packed {
    int         cyc;
    logic [2:0] ph;
    logic       dr;
    logic       ovr;
  } xfer_t;

  probe_t pq[$];
  xfer_t  xq[$];
  probe_t p;
  xfer_t  x;
  int     tests = 0;
  int     fails = 0;
  int     cyc   = 0;

  // Phase/dir presented at each accepted step during the bounce run.
  int ph_seq [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int dir_seq[16] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle 0 is the first cycle with reset low (the IDLE cycle).
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      while (pq.size() > 0 && pq[0].cyc == cyc) begin
        p = pq.pop_front();
        tests++;
        if ({step_valid, phase, dir, overrun, running} !== {p.valid, p.ph, p.dr, p.ovr, p.run}) begin
          fails++;
          $display("FAIL probe cyc=%0d: got valid=%0b phase=%0d dir=%0b overrun=%0b running=%0b, want valid=%0b phase=%0d dir=%0b overrun=%0b running=%0b",
                   cyc, step_valid, phase, dir, overrun, running, p.valid, p.ph, p.dr, p.ovr, p.run);
        end
      end
      if (step_valid && step_ready) begin
        tests++;
        if (xq.size() == 0) begin
          fails++;
          $display("FAIL xfer unexpected at cyc=%0d phase=%0d dir=%0b", cyc, phase, dir);
        end else begin
          x = xq.pop_front();
          if ({cyc, phase, dir, overrun} !== {x.cyc, x.ph, x.dr, x.ovr}) begin
            fails++;
            $display("FAIL xfer: got cyc=%0d phase=%0d dir=%0b overrun=%0b, want cyc=%0d phase=%0d dir=%0b overrun=%0b",
                     cyc, phase, dir, overrun, x.cyc, x.ph, x.dr, x.ovr);
          end
        end
      end
    end
  end

  task automatic push_probe(input int c, input logic v, input int ph, input logic d,
                            input logic o, input logic r);
    probe_t e;
    e.cyc = c; e.valid = v; e.ph = 3'(ph); e.dr = d; e.ovr = o; e.run = r;
    pq.push_back(e);
  endtask

  task automatic push_xfer(input int c, input int ph, input logic d, input logic o);
    xfer_t e;
    e.cyc = c; e.ph = 3'(ph); e.dr = d; e.ovr = o;
    xq.push_back(e);
  endtask

  task automatic start_reset(input logic [2:0] spd, input logic rdy);
    reset      = 1'b1;
    speed      = spd;
    hold       = 1'b0;
    step_ready = rdy;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Advance to just after the edge that starts cycle n (bounded).
  task automatic at_cycle(input int n);
    int guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (cyc != n && guard < 2000);
    tests++;
    if (cyc != n) begin
      fails++;
      $display("FAIL at_cycle timeout: got cyc=%0d, want %0d", cyc, n);
    end
  endtask

  task automatic check_empty(input string name);
    tests++;
    if (pq.size() != 0 || xq.size() != 0) begin
      fails++;
      $display("FAIL %s leftover: got probes=%0d xfers=%0d, want 0 and 0", name, pq.size(), xq.size());
    end
    pq.delete();
    xq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; speed = 3'd0; hold = 1'b0; step_ready = 1'b0;

    // Free-running bounce at the fastest rate with an always-ready sink.
    start_reset(3'd0, 1'b1);
    push_probe(0, 0, 0, 1, 0, 0);
    push_probe(1, 0, 0, 1, 0, 1);
    push_probe(6, 0, 1, 1, 0, 1);
    for (int k = 0; k < 16; k++) push_xfer(5 + 4 * k, ph_seq[k], dir_seq[k][0], 1'b0);
    push_probe(66, 0, 2, 1, 0, 1);
    release_reset();
    at_cycle(68);
    check_empty("bounce");

    // Speed 0 -> 7 mid-period: old period finishes, next period is 512 cycles.
    start_reset(3'd0, 1'b1);
    push_xfer(5, 0, 1, 0);
    push_xfer(9, 1, 1, 0);
    push_probe(13, 0, 2, 1, 0, 1);
    push_probe(520, 0, 2, 1, 0, 1);
    push_xfer(521, 2, 1, 0);
    push_probe(522, 0, 3, 1, 0, 1);
    release_reset();
    at_cycle(6);
    speed = 3'd7;
    at_cycle(524);
    check_empty("speed_change");

    // Sink stalled: step stays pending, overrun latches, one transfer at cycle 20.
    start_reset(3'd0, 1'b0);
    push_probe(4, 0, 0, 1, 0, 1);
    push_probe(5, 1, 0, 1, 0, 1);
    push_probe(8, 1, 0, 1, 0, 1);
    push_probe(9, 1, 0, 1, 1, 1);
    push_probe(19, 1, 0, 1, 1, 1);
    push_xfer(20, 0, 1, 1);
    push_probe(21, 1, 1, 1, 1, 1);
    release_reset();
    at_cycle(20);
    step_ready = 1'b1;
    at_cycle(21);
    step_ready = 1'b0;
    at_cycle(23);
    check_empty("overrun");

    // Hold for cycles 2..11 stretches the first period to cycle 15.
    start_reset(3'd0, 1'b1);
    push_probe(7, 0, 0, 1, 0, 1);
    push_probe(14, 0, 0, 1, 0, 1);
    push_xfer(15, 0, 1, 0);
    push_probe(16, 0, 1, 1, 0, 1);
    push_xfer(19, 1, 1, 0);
    release_reset();
    at_cycle(2);
    hold = 1'b1;
    at_cycle(12);
    hold = 1'b0;
    at_cycle(21);
    check_empty("hold");

    // Ready raised on a tick cycle: valid stays up with no gap, no overrun.
    start_reset(3'd0, 1'b0);
    push_probe(5, 1, 0, 1, 0, 1);
    push_xfer(8, 0, 1, 0);
    push_probe(9, 1, 1, 1, 0, 1);
    push_xfer(9, 1, 1, 0);
    push_probe(10, 0, 2, 1, 0, 1);
    push_xfer(13, 2, 1, 0);
    release_reset();
    at_cycle(8);
    step_ready = 1'b1;
    at_cycle(15);
    check_empty("coincident");

    // One-cycle reset while a phase-3 step is pending, then IDLE timing again.
    start_reset(3'd0, 1'b1);
    push_xfer(5, 0, 1, 0);
    push_xfer(9, 1, 1, 0);
    push_xfer(13, 2, 1, 0);
    push_probe(17, 1, 3, 1, 0, 1);
    release_reset();
    at_cycle(14);
    step_ready = 1'b0;
    at_cycle(17);
    @(negedge clk);
    #1;
    reset = 1'b1;
    push_probe(0, 0, 0, 1, 0, 0);
    push_probe(4, 0, 0, 1, 0, 1);
    push_xfer(5, 0, 1, 0);
    push_probe(6, 0, 1, 1, 0, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step_ready = 1'b1;
    at_cycle(7);
    check_empty("mid_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
